inst_mem_responder: RTL

//   Responder end of the instruction-fetch interface. Accepts a PC-addressed

---
 rtl/inst_mem_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/inst_mem_responder.sv
// inst_mem_responder: responder end of the instruction-fetch interface.
// Accepts a PC fetch, waits WAIT_STATES cycles, then returns one word with a
// one-cycle valid strobe. Misaligned / out-of-range fetches return NOP_WORD
// with access_fault. A preload write port fills the array independently.
module inst_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    input  logic        i_flush,
    output logic [31:0] o_inst,
    output logic        o_inst_valid,
    output logic        o_busy,
    output logic        o_access_fault,
    input  logic        i_prog_we,
    input  logic [31:0] i_prog_addr,
    input  logic [31:0] i_prog_data
);
    localparam int         AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    state_t      w_accept_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_inst;
    logic        r_flt;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_load;
    logic        w_rd_flt;
    logic        w_prog_ok;
    logic [31:0] w_rd_addr;

    // An address is unusable if it is not word aligned or indexes past the array.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
    endfunction

    // With zero wait states a request goes straight to the response cycle.
    assign w_accept_state = (WS == 4'd0) ? S_RESP : S_WAIT;

    // A request is taken only when not busy and not being flushed.
    assign w_accept  = i_req_valid && !i_flush && (r_state != S_WAIT);

    // While waiting the latched PC is used; otherwise the live PC (zero-wait path).
    assign w_rd_addr = (r_state == S_WAIT) ? r_addr : i_req_addr;
    assign w_rd_flt  = addr_bad(w_rd_addr);
    assign w_load    = (w_next == S_RESP);
    assign w_prog_ok = !addr_bad(i_prog_addr);
    assign o_inst    = r_inst;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; flush returns to idle from any busy/response state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_accept_state;
            S_WAIT: begin
                if (i_flush)              w_next = S_IDLE;
                else if (r_cnt == 4'd1)   w_next = S_RESP;
            end
            S_RESP: begin
                if (i_flush)       w_next = S_IDLE;
                else if (w_accept) w_next = w_accept_state;
                else               w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state; fault is only visible alongside the strobe.
    always_comb begin
        o_inst_valid   = 1'b0;
        o_busy         = 1'b0;
        o_access_fault = 1'b0;
        case (r_state)
            S_WAIT: o_busy = 1'b1;
            S_RESP: begin
                o_inst_valid   = 1'b1;
                o_access_fault = r_flt;
            end
            default: ;
        endcase
    end

    // Wait-state counter: loaded on accept, counts down while waiting.
    always_ff @(posedge i_clk) begin
        if (!i_rst)                                r_cnt <= 4'd0;
        else if (w_accept)                         r_cnt <= WS;
        else if (i_flush)                          r_cnt <= 4'd0;
        else if (r_state == S_WAIT && r_cnt != 0)  r_cnt <= r_cnt - 4'd1;
    end

    // Latch the PC of an accepted request for use after the wait states.
    always_ff @(posedge i_clk) begin
        if (!i_rst)        r_addr <= '0;
        else if (w_accept) r_addr <= i_req_addr;
    end

    // Instruction register: array read (old data on same-edge write) on entry
    // to the response cycle, NOP on reset/flush/fault, held otherwise.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_inst <= NOP_WORD;
            r_flt  <= 1'b0;
        end else if (i_flush && r_state != S_IDLE) begin
            r_inst <= NOP_WORD;
            r_flt  <= 1'b0;
        end else if (w_load) begin
            r_inst <= w_rd_flt ? NOP_WORD : r_mem[w_rd_addr[AW+1:2]];
            r_flt  <= w_rd_flt;
        end
    end

    // Preload port; not reset so program contents survive a core reset.
    always_ff @(posedge i_clk) begin
        if (i_prog_we && w_prog_ok) r_mem[i_prog_addr[AW+1:2]] <= i_prog_data;
    end

endmodule
